// File: rtl/ttl_update_stage_if.sv
// AXI4-Stream bundle shared by the upstream and downstream sides of ttl_update_stage.
interface ttl_update_stage_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ttl_update_stage.sv
// TTL decrement + incremental IPv4 checksum update on each packet's first beat.
// TTL_UPDATE_EXPIRED_TO_CPU_EN: redirect expired packets to the CPU queue instead of dropping them.
module ttl_update_stage #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  ttl_update_stage_if.slave             s_axis,
  ttl_update_stage_if.master            m_axis,
  input  logic                          clear_counters,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ttl_dec_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ttl_expired_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] non_ip_pass_count
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int CW = C_S_AXI_DATA_WIDTH;

  typedef enum logic {HDR, BODY} state_t;

  state_t            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW/8-1:0]   strb_q, strb_d;
  logic [UW-1:0]     user_q, user_d;
  logic              last_q, last_d;
  logic              exp_q, exp_d;
  logic [CW-1:0]     dec_cnt_q, dec_cnt_d;
  logic [CW-1:0]     exp_cnt_q, exp_cnt_d;
  logic [CW-1:0]     non_cnt_q, non_cnt_d;
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
  logic [7:0]        dst_q, dst_d;
  logic [7:0]        redirect;
`endif

  logic              s_ready, accept, in_hdr, is_ip, expired_in, pkt_expired;
  logic [7:0]        ttl_in;
  logic [16:0]       csum_sum;
  logic [15:0]       csum_new;
  logic [DW-1:0]     hdr_data;

  always_comb begin
    s_ready    = !m_valid_q || m_axis.tready;
    accept     = s_axis.tvalid && s_ready;
    in_hdr     = (state_q == HDR);
    is_ip      = (s_axis.tdata[159:144] == 16'h0800) && (s_axis.tdata[143:140] == 4'd4);
    ttl_in     = s_axis.tdata[79:72];
    expired_in = is_ip && (ttl_in <= 8'd1);
    pkt_expired = in_hdr ? expired_in : exp_q;
    // TTL sits in the high byte of its header word, so -1 on TTL is +0x0100 on the checksum.
    csum_sum   = {1'b0, s_axis.tdata[63:48]} + 17'h00100;
    csum_new   = csum_sum[15:0] + 16'(csum_sum[16]);
    hdr_data   = s_axis.tdata;
    if (is_ip && !expired_in) begin
      hdr_data[79:72] = 8'(ttl_in - 8'd1);
      hdr_data[63:48] = csum_new;
    end
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
    redirect = {s_axis.tuser[SRC_PORT_POS+:7], 1'b0};
`endif
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    data_d    = data_q;
    strb_d    = strb_q;
    user_d    = user_q;
    last_d    = last_q;
    exp_d     = exp_q;
    dec_cnt_d = dec_cnt_q;
    exp_cnt_d = exp_cnt_q;
    non_cnt_d = non_cnt_q;
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
    dst_d     = dst_q;
`endif
    if (accept) begin
      data_d  = in_hdr ? hdr_data : s_axis.tdata;
      strb_d  = s_axis.tstrb;
      user_d  = s_axis.tuser;
      last_d  = s_axis.tlast;
      exp_d   = pkt_expired && !s_axis.tlast;
      state_d = s_axis.tlast ? HDR : BODY;
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
      m_valid_d = 1'b1;
      if (in_hdr) dst_d = redirect;
      if (pkt_expired) user_d[DST_PORT_POS+:8] = in_hdr ? redirect : dst_q;
`else
      m_valid_d = !pkt_expired;
`endif
      if (in_hdr) begin
        if (!is_ip)          non_cnt_d = non_cnt_q + CW'(1);
        else if (expired_in) exp_cnt_d = exp_cnt_q + CW'(1);
        else                 dec_cnt_d = dec_cnt_q + CW'(1);
      end
    end else if (m_axis.tready) begin
      m_valid_d = 1'b0;
    end
    if (clear_counters) begin
      dec_cnt_d = '0;
      exp_cnt_d = '0;
      non_cnt_d = '0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q   <= HDR;
      m_valid_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
      user_q    <= '0;
      last_q    <= 1'b0;
      exp_q     <= 1'b0;
      dec_cnt_q <= '0;
      exp_cnt_q <= '0;
      non_cnt_q <= '0;
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
      dst_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      user_q    <= user_d;
      last_q    <= last_d;
      exp_q     <= exp_d;
      dec_cnt_q <= dec_cnt_d;
      exp_cnt_q <= exp_cnt_d;
      non_cnt_q <= non_cnt_d;
`ifdef TTL_UPDATE_EXPIRED_TO_CPU_EN
      dst_q     <= dst_d;
`endif
    end
  end

  assign s_axis.tready     = s_ready;
  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = data_q;
  assign m_axis.tstrb      = strb_q;
  assign m_axis.tuser      = user_q;
  assign m_axis.tlast      = last_q;
  assign ttl_dec_count     = dec_cnt_q;
  assign ttl_expired_count = exp_cnt_q;
  assign non_ip_pass_count = non_cnt_q;
endmodule
